// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32IM core.
// Contents: fetch FSM state encoding, core phase constants,
// the canonical NOP word and the fetch fault cause codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_DONE  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    // Core phase as driven by the control unit.
    localparam logic STATE_FETCH   = 1'b0;
    localparam logic STATE_EXECUTE = 1'b1;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for the fetch memory handshake.
// Ports:
//   clk, reset  - core clock, synchronous active-high reset
//   clear       - return count to zero (held while not requesting)
//   enable      - one request cycle elapsed without acknowledge
//   expired     - high in the TIMEOUT-th unacknowledged request cycle
// TIMEOUT = 0 disables expiry entirely.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counts 0..TIMEOUT-1; expiry fires on the cycle that would make TIMEOUT.
    localparam int unsigned W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [W-1:0] cnt;

    assign expired = (TIMEOUT != 0) && enable && (cnt == W'(LAST));

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the multi-cycle RV32IM core.
// Owns the PC, issues one read per FETCH phase over a req/ack handshake,
// hands the word to the instruction register, and advances the PC at the
// end of EXECUTE (sequential or redirect). Bus timeout and misaligned
// redirect raise a sticky fault that only reset clears.
// Ports:
//   clk, reset                    - core clock, synchronous active-high reset
//   state                         - core phase (0 FETCH, 1 EXECUTE)
//   exec_done, branch_taken,
//   branch_target                 - PC advance pulse and redirect info
//   mem_req, mem_addr             - read request (level) and word address
//   mem_ack, mem_rdata            - acknowledge and instruction word
//   instr, instr_valid            - fetched word and its one-cycle strobe
//   pc                            - address of the current instruction
//   fetch_fault, fault_cause      - sticky fault flag and its cause code
// RESET_PC must be word-aligned.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    fetch_state_e st, st_n;
    logic [31:0]  pc_n, instr_n;
    logic         req_n, valid_n, fault_n;
    logic [1:0]   cause_n;
    logic         cnt_clr, cnt_en, expired;

    // Counter runs only while a request is outstanding and unanswered.
    assign cnt_clr = (st != FS_REQ);
    assign cnt_en  = (st == FS_REQ) && !mem_ack;

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (expired)
    );

    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= FS_IDLE;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            st          <= st_n;
            pc          <= pc_n;
            mem_req     <= req_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            fetch_fault <= fault_n;
            fault_cause <= cause_n;
        end
    end

    always_comb begin
        st_n    = st;
        pc_n    = pc;
        req_n   = mem_req;
        instr_n = instr;
        valid_n = 1'b0;
        fault_n = fetch_fault;
        cause_n = fault_cause;
        case (st)
            FS_IDLE: begin
                if (state == STATE_FETCH) begin
                    st_n  = FS_REQ;
                    req_n = 1'b1;
                end
            end
            // A phase change to EXECUTE here deliberately does not abort.
            FS_REQ: begin
                if (mem_ack) begin
                    instr_n = mem_rdata;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    st_n    = FS_DONE;
                end else if (expired) begin
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                    cause_n = CAUSE_TIMEOUT;
                    st_n    = FS_FAULT;
                end
            end
            FS_DONE: begin
                if (exec_done) begin
                    if (branch_taken) begin
                        if (branch_target[1:0] != 2'b00) begin
                            // PC stays on the instruction that redirected.
                            fault_n = 1'b1;
                            cause_n = CAUSE_MISALIGN;
                            st_n    = FS_FAULT;
                        end else begin
                            pc_n = branch_target;
                            st_n = FS_IDLE;
                        end
                    end else begin
                        pc_n = pc + 32'd4;
                        st_n = FS_IDLE;
                    end
                end
            end
            FS_FAULT: begin
                req_n   = 1'b0;
                fault_n = 1'b1;
            end
            default: st_n = FS_IDLE;
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle RV32IM core, directly upstream of the instruction register. It owns the program counter, reads one instruction word per FETCH phase over a request/acknowledge memory handshake, and presents it to the instruction register as `instr`/`instr_valid`. At the end of each EXECUTE phase it advances the PC, either sequentially or to a redirect target. A bus timeout and a misaligned-target check raise a sticky fault.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset; must be word-aligned.
- `TIMEOUT`, 255, maximum wait cycles for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  core clock; one clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `state`  in  1  core phase from control: 0 = FETCH, 1 = EXECUTE.
- `exec_done`  in  1  one-cycle pulse, EXECUTE finished, advance PC.
- `branch_taken`  in  1  qualifies `exec_done`: load `branch_target` instead of PC+4.
- `branch_target`  in  32  redirect address from execute.
- `mem_req`  out  1  read request, level, held until acknowledged.
- `mem_addr`  out  32  word address of the request, equals `pc`.
- `mem_ack`  in  1  memory accepted request, `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  instruction word.
- `instr`  out  32  fetched instruction; drives instruction register `in`.
- `instr_valid`  out  1  one-cycle pulse; drives instruction register `valid`.
- `pc`  out  32  address of the current instruction.
- `fetch_fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  0 none, 1 bus timeout, 2 misaligned target.

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE: when `state`==0, go to REQ; `mem_req` rises on that same edge (registered), `mem_addr`=`pc`.
- REQ: `mem_req`=1, `mem_addr` stable. On `mem_ack`=1: capture `mem_rdata` into `instr`, pulse `instr_valid`, clear `mem_req`, go to DONE. Otherwise increment wait counter; when counter reaches `TIMEOUT` (and `TIMEOUT`≠0) go to FAULT with cause 1, `mem_req` cleared.
- A FETCH→EXECUTE change of `state` during REQ does not abort the request.
- DONE: wait for `exec_done`. On it: if `branch_taken`, check `branch_target[1:0]`; nonzero → FAULT cause 2, `pc` unchanged; else `pc`←`branch_target`. If not taken, `pc`←`pc`+4 (32-bit modular; 32'hFFFF_FFFC wraps to 0). Then IDLE.
- `exec_done` outside DONE is ignored. `mem_ack` outside REQ is ignored.
- FAULT: terminal until `reset`; `mem_req`=0, `instr_valid`=0, `fetch_fault`=1, `pc` frozen.

## Timing
- Reset values: `pc`=`mem_addr`=`RESET_PC`, `mem_req`=0, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `fetch_fault`=0, `fault_cause`=0, FSM IDLE, counter 0.
- Latency: IDLE seen with `state`=0 at edge N → `mem_req`=1 after N. `mem_ack` sampled at edge M → `instr`/`instr_valid` valid after M, `instr_valid` high exactly one cycle.
- Zero-wait memory (ack on first request cycle): 2 cycles from FETCH entry to `instr_valid`.
- `exec_done` at edge E → new `pc` after E; next request no earlier than E+1.
- Timeout: fault raised after exactly `TIMEOUT` request cycles without ack.
- Reset mid-transaction: `mem_req` low after the reset edge; an ack in the following cycle is ignored.
- Reset wins over every simultaneous event.

## Structure
- Shared package `cpu_pkg`: FSM state enum, `STATE_FETCH`/`STATE_EXECUTE` constants, `NOP_INSTR`, fault cause codes.
- One sub-module natural: `fetch_timeout_counter` (clear, enable, `TIMEOUT` parameter, expired output).

## Test plan
- Reset, zero-wait memory returning 32'h0030_0093 at 0x0 → `mem_req` cycle 1, `instr`=32'h0030_0093 with `instr_valid` one cycle at cycle 2.
- Three sequential fetches, ack delayed 3 cycles each → `mem_addr` 0x0, 0x4, 0x8; `mem_addr` stable while `mem_req` high.
- `exec_done`+`branch_taken`, target 0x100 → next `mem_addr`=0x100; target 0x102 → `fetch_fault`=1, `fault_cause`=2, `pc` unchanged, no further `mem_req`.
- `TIMEOUT`=4, never ack → `mem_req` high 4 cycles, then `fault_cause`=1; `TIMEOUT`=0 → waits indefinitely, no fault.
- `RESET_PC`=32'hFFFF_FFFC, sequential `exec_done` → next `mem_addr`=0x0.
- Reset asserted while `mem_req`=1, ack next cycle → `instr_valid` stays 0, `pc`=`RESET_PC`.
